// File: rtl/motion_pkg.sv
// Shared types and sizing helpers for the motion frame sequencer slice.
package motion_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_WAIT,
      S_REPORT
   } seq_state_t;

   // Pixels in one frame.
   function automatic int frame_size(input int width, input int height);
      return width * height;
   endfunction

   // Cells in the detector's square activity grid.
   function automatic int grid_cells(input int grid_size);
      return grid_size * grid_size;
   endfunction

   // The captured result carries the grid of the standard 4x4 detector.
   localparam int DEF_GRID_SIZE = 4;
   localparam int RES_GRID_BITS = grid_cells(DEF_GRID_SIZE);

   typedef struct packed {
      logic                     motion;
      logic [7:0]               intensity;
      logic [RES_GRID_BITS-1:0] grid;
      logic                     timeout;
   } result_t;

endpackage

// File: rtl/motion_hysteresis.sv
// Temporal hysteresis: turns per-frame motion results into a stable alarm.
module motion_hysteresis #(
   parameter int CONFIRM_FRAMES = 2,
   parameter int CLEAR_FRAMES   = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic upd_valid,
   input  logic motion,
   output logic motion_alarm
);

   localparam int MC_W = $clog2(CONFIRM_FRAMES + 1);
   localparam int QC_W = $clog2(CLEAR_FRAMES + 1);
   localparam logic [MC_W-1:0] MC_MAX = MC_W'(CONFIRM_FRAMES);
   localparam logic [QC_W-1:0] QC_MAX = QC_W'(CLEAR_FRAMES);

   logic [MC_W-1:0] motion_cnt, motion_nxt;
   logic [QC_W-1:0] quiet_cnt, quiet_nxt;

   // Saturating successors of both run counters.
   always_comb begin
      // NOTE: each output of an always_comb gets a value on every path, otherwise a latch is inferred.
      motion_nxt = motion_cnt;
      quiet_nxt  = quiet_cnt;
      if (motion_cnt != MC_MAX) motion_nxt = motion_cnt + 1'b1;
      if (quiet_cnt != QC_MAX)  quiet_nxt  = quiet_cnt + 1'b1;
   end

   // Run counters and alarm update only on a qualified result.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
      if (!rst_n) begin
         motion_cnt   <= '0;
         quiet_cnt    <= '0;
         motion_alarm <= 1'b0;
      end else if (upd_valid) begin
         if (motion) begin
            quiet_cnt  <= '0;
            motion_cnt <= motion_nxt;
            if (motion_nxt == MC_MAX) motion_alarm <= 1'b1;
         end else begin
            motion_cnt <= '0;
            quiet_cnt  <= quiet_nxt;
            if (quiet_nxt == QC_MAX) motion_alarm <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/motion_frame_sequencer.sv
// Streams whole frames into motion_detector, collects its result, applies
// decimation, warm-up suppression, a frame_done watchdog and hysteresis.
module motion_frame_sequencer
   import motion_pkg::*;
#(
   parameter int IMG_WIDTH      = 16,
   parameter int IMG_HEIGHT     = 16,
   parameter int PIXEL_WIDTH    = 8,
   parameter int GRID_SIZE      = 4,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CONFIRM_FRAMES = 2,
   parameter int CLEAR_FRAMES   = 3
) (
   input  logic                                               clk,
   input  logic                                               rst_n,
   input  logic                                               enable,
   input  logic [3:0]                                         cfg_skip,
   input  logic                                               frame_ready,
   output logic                                               frame_ack,
   output logic                                               mem_rd_en,
   output logic [$clog2(frame_size(IMG_WIDTH, IMG_HEIGHT))-1:0] mem_rd_addr,
   input  logic [PIXEL_WIDTH-1:0]                             mem_rd_data,
   output logic                                               det_pixel_valid,
   output logic [PIXEL_WIDTH-1:0]                             det_pixel_data,
   input  logic                                               det_frame_done,
   input  logic                                               det_motion_detected,
   input  logic [7:0]                                         det_motion_intensity,
   input  logic [grid_cells(GRID_SIZE)-1:0]                   det_grid_activity,
   output logic                                               res_valid,
   output logic                                               res_motion,
   output logic [7:0]                                         res_intensity,
   output logic [grid_cells(GRID_SIZE)-1:0]                   res_grid,
   output logic                                               res_timeout,
   output logic                                               motion_alarm,
   output logic                                               busy,
   output logic [15:0]                                        stat_frames,
   output logic [15:0]                                        stat_motion
);

   localparam int FRAME_SIZE = frame_size(IMG_WIDTH, IMG_HEIGHT);
   localparam int ADDR_W     = $clog2(FRAME_SIZE);
   localparam int WD_W       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_SIZE - 1);
   // The first S_WAIT cycle carries the last beat, so the limit is one short.
   localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);

   seq_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              prime_q, prime_d;
   logic [WD_W-1:0]   wd_q, wd_d;
   logic [3:0]        skip_q, skip_d;
   logic              warmup_q, warmup_d;
   result_t           res_q, res_d;
   logic [15:0]       frames_q, frames_d;
   logic [15:0]       motions_q, motions_d;
   logic              det_valid_q;
   logic              hyst_upd;

   // Next-state and Moore/Mealy outputs of the sequencer.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      prime_d   = prime_q;
      wd_d      = wd_q;
      skip_d    = skip_q;
      warmup_d  = warmup_q;
      res_d     = res_q;
      frames_d  = frames_q;
      motions_d = motions_q;
      mem_rd_en = 1'b0;
      frame_ack = 1'b0;
      res_valid = 1'b0;
      hyst_upd  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (enable && frame_ready) begin
               if (skip_q != '0) begin
                  frame_ack = 1'b1;
                  skip_d    = skip_q - 4'd1;
               end else begin
                  state_d = S_STREAM;
                  addr_d  = '0;
                  prime_d = 1'b1;
               end
            end
         end
         S_STREAM: begin
            mem_rd_en = 1'b1;
            if (prime_q) begin
               // Address 0 is read twice: the detector eats the first beat as a start marker.
               prime_d = 1'b0;
            end else if (addr_q == LAST_ADDR) begin
               state_d = S_WAIT;
               addr_d  = '0;
               wd_d    = '0;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         S_WAIT: begin
            if (det_frame_done) begin
               res_d.motion    = det_motion_detected;
               res_d.intensity = det_motion_intensity;
               res_d.grid      = det_grid_activity;
               res_d.timeout   = 1'b0;
               state_d         = S_REPORT;
            end else if (wd_q == WD_LAST) begin
               res_d         = '0;
               res_d.timeout = 1'b1;
               state_d       = S_REPORT;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         S_REPORT: begin
            frame_ack = 1'b1;
            skip_d    = cfg_skip;
            state_d   = S_IDLE;
            if (warmup_q) begin
               warmup_d = 1'b0;
            end else begin
               res_valid = 1'b1;
               frames_d  = frames_q + 16'd1;
               motions_d = motions_q + 16'(res_q.motion);
               hyst_upd  = !res_q.timeout;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Sequencer state, captured result, statistics and the beat-valid pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         prime_q     <= 1'b0;
         wd_q        <= '0;
         skip_q      <= '0;
         warmup_q    <= 1'b1;
         res_q       <= '0;
         frames_q    <= '0;
         motions_q   <= '0;
         det_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         prime_q     <= prime_d;
         wd_q        <= wd_d;
         skip_q      <= skip_d;
         warmup_q    <= warmup_d;
         res_q       <= res_d;
         frames_q    <= frames_d;
         motions_q   <= motions_d;
         det_valid_q <= mem_rd_en;
      end
   end

   motion_hysteresis #(
      .CONFIRM_FRAMES (CONFIRM_FRAMES),
      .CLEAR_FRAMES   (CLEAR_FRAMES)
   ) u_hysteresis (
      .clk          (clk),
      .rst_n        (rst_n),
      .upd_valid    (hyst_upd),
      .motion       (res_q.motion),
      .motion_alarm (motion_alarm)
   );

   assign mem_rd_addr     = addr_q;
   assign det_pixel_valid = det_valid_q;
   assign det_pixel_data  = det_valid_q ? mem_rd_data : '0;
   assign res_motion      = res_q.motion;
   assign res_intensity   = res_q.intensity;
   assign res_grid        = res_q.grid;
   assign res_timeout     = res_q.timeout;
   assign busy            = (state_q != S_IDLE);
   assign stat_frames     = frames_q;
   assign stat_motion     = motions_q;

endmodule

// File: tb/tb_motion_frame_sequencer.sv
// Self-checking bench for motion_frame_sequencer: random frames and detector
// results against a frame-level reference model.
module tb_motion_frame_sequencer;

   localparam int BEATS      = 257;
   localparam int TIMEOUT    = 64;
   localparam int CONFIRM    = 2;
   localparam int CLEAR      = 3;
   localparam int GRID_CELLS = 16;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  enable;
   logic [3:0]            cfg_skip;
   logic                  frame_ready;
   logic                  frame_ack;
   logic                  mem_rd_en;
   logic [7:0]            mem_rd_addr;
   logic [7:0]            mem_rd_data;
   logic                  det_pixel_valid;
   logic [7:0]            det_pixel_data;
   logic                  det_frame_done;
   logic                  det_motion_detected;
   logic [7:0]            det_motion_intensity;
   logic [GRID_CELLS-1:0] det_grid_activity;
   logic                  res_valid;
   logic                  res_motion;
   logic [7:0]            res_intensity;
   logic [GRID_CELLS-1:0] res_grid;
   logic                  res_timeout;
   logic                  motion_alarm;
   logic                  busy;
   logic [15:0]           stat_frames;
   logic [15:0]           stat_motion;

   motion_frame_sequencer dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .enable               (enable),
      .cfg_skip             (cfg_skip),
      .frame_ready          (frame_ready),
      .frame_ack            (frame_ack),
      .mem_rd_en            (mem_rd_en),
      .mem_rd_addr          (mem_rd_addr),
      .mem_rd_data          (mem_rd_data),
      .det_pixel_valid      (det_pixel_valid),
      .det_pixel_data       (det_pixel_data),
      .det_frame_done       (det_frame_done),
      .det_motion_detected  (det_motion_detected),
      .det_motion_intensity (det_motion_intensity),
      .det_grid_activity    (det_grid_activity),
      .res_valid            (res_valid),
      .res_motion           (res_motion),
      .res_intensity        (res_intensity),
      .res_grid             (res_grid),
      .res_timeout          (res_timeout),
      .motion_alarm         (motion_alarm),
      .busy                 (busy),
      .stat_frames          (stat_frames),
      .stat_motion          (stat_motion)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   logic [7:0] frame_mem [256];

   // Reference model state, kept at frame granularity.
   int         m_skip, m_frames, m_motion, m_mrun, m_qrun;
   bit         m_warm, m_alarm;
   bit         m_last_motion, m_last_timeout;
   logic [7:0] m_last_int;
   bit         last_streamed;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_skip = 0; m_frames = 0; m_motion = 0; m_mrun = 0; m_qrun = 0;
      m_warm = 1'b1; m_alarm = 1'b0;
      m_last_motion = 1'b0; m_last_timeout = 1'b0; m_last_int = 8'h00;
   endtask

   // Advance one clock; the frame buffer answers a read one cycle later.
   task automatic cycle();
      logic       re;
      logic [7:0] ad;
      re = mem_rd_en;
      ad = mem_rd_addr;
      @(posedge clk);
      #1;
      mem_rd_data = re ? frame_mem[ad] : 8'($urandom);
      cyc++;
   endtask

   function automatic int exp_addr(input int k);
      return (k == 0) ? 0 : k - 1;
   endfunction

   // Offer one ready frame and follow it until it is acknowledged.
   task automatic offer_frame(input bit withhold, input bit mot, input logic [7:0] inten,
                              input int lat, input int drop_en_at, input int drop_rdy_at,
                              input bit spurious);
      logic [GRID_CELLS-1:0] grid;
      logic [7:0]            r_int;
      logic [GRID_CELLS-1:0] r_grid;
      int start, beats, nrd, first, last, res_cyc, ack_cyc;
      bit addr_ok, data_ok, r_mot, r_to, streamed, e_mot;
      grid = GRID_CELLS'($urandom);
      foreach (frame_mem[i]) frame_mem[i] = 8'($urandom);
      streamed = (m_skip == 0);
      frame_ready = 1'b1;
      start = cyc; beats = 0; nrd = 0; first = -1; last = -1; res_cyc = -1; ack_cyc = -1;
      addr_ok = 1'b1; data_ok = 1'b1; r_mot = 1'b0; r_to = 1'b0; r_int = '0; r_grid = '0;
      for (int n = 0; n < 1000 && ack_cyc < 0; n++) begin
         det_frame_done       = 1'b0;
         det_motion_detected  = 1'($urandom);
         det_motion_intensity = 8'($urandom);
         det_grid_activity    = GRID_CELLS'($urandom);
         if (spurious && beats == 50) begin
            det_frame_done      = 1'b1;
            det_motion_detected = !mot;
         end
         if (!withhold && beats == BEATS && cyc - last == lat) begin
            det_frame_done       = 1'b1;
            det_motion_detected  = mot;
            det_motion_intensity = inten;
            det_grid_activity    = grid;
         end
         if (beats == drop_en_at)  enable = 1'b0;
         if (beats == drop_rdy_at) frame_ready = 1'b0;
         #1;
         if (mem_rd_en) begin
            if (nrd >= BEATS || mem_rd_addr !== 8'(exp_addr(nrd))) addr_ok = 1'b0;
            nrd++;
         end
         if (det_pixel_valid) begin
            if (beats >= BEATS || det_pixel_data !== frame_mem[exp_addr(beats)]) data_ok = 1'b0;
            if (beats == 0) first = cyc;
            beats++;
            last = cyc;
         end
         if (res_valid) begin
            res_cyc = cyc; r_mot = res_motion; r_int = res_intensity; r_grid = res_grid; r_to = res_timeout;
         end
         if (frame_ack) ack_cyc = cyc;
         cycle();
      end
      frame_ready = 1'b1;
      last_streamed = streamed;
      check("frame_acked", 32'(ack_cyc >= 0), 1);
      if (streamed) begin
         e_mot = withhold ? 1'b0 : mot;
         check("beat_count", beats, BEATS);
         check("beats_contiguous", last - first + 1, BEATS);
         check("read_addr_seq", 32'(addr_ok && nrd == BEATS), 1);
         check("pixel_data", 32'(data_ok), 1);
         check("ack_latency", ack_cyc - last, withhold ? TIMEOUT : lat + 1);
         check("res_valid_seen", 32'(res_cyc >= 0), 32'(!m_warm));
         if (!m_warm) begin
            check("res_valid_with_ack", res_cyc, ack_cyc);
            check("res_motion", r_mot, e_mot);
            check("res_intensity", r_int, withhold ? 8'h00 : inten);
            check("res_grid", r_grid, withhold ? '0 : grid);
            check("res_timeout", r_to, withhold);
            m_frames++;
            m_motion += e_mot;
            if (!withhold) begin
               if (e_mot) begin
                  m_mrun++; m_qrun = 0;
                  if (m_mrun >= CONFIRM) m_alarm = 1'b1;
               end else begin
                  m_qrun++; m_mrun = 0;
                  if (m_qrun >= CLEAR) m_alarm = 1'b0;
               end
            end
         end
         m_warm = 1'b0;
         m_skip = int'(cfg_skip);
         m_last_motion = e_mot; m_last_timeout = withhold; m_last_int = withhold ? 8'h00 : inten;
      end else begin
         check("skip_ack_1cycle", ack_cyc - start, 0);
         check("skip_no_beats", beats + nrd, 0);
         check("skip_no_res_valid", 32'(res_cyc >= 0), 0);
         check("res_hold", {res_motion, res_timeout, res_intensity},
               {m_last_motion, m_last_timeout, m_last_int});
         m_skip--;
      end
      check("stat_frames", stat_frames, 16'(m_frames));
      check("stat_motion", stat_motion, 16'(m_motion));
      check("motion_alarm", motion_alarm, m_alarm);
   endtask

   initial begin
      logic [8:0] pattern;
      bit         quiet_ok;
      rst_n = 1'b0; enable = 1'b0; cfg_skip = '0; frame_ready = 1'b0; mem_rd_data = '0;
      det_frame_done = 1'b0; det_motion_detected = 1'b0; det_motion_intensity = '0; det_grid_activity = '0;
      model_reset();
      repeat (3) cycle();
      check("reset_outputs_zero", 32'({frame_ack, mem_rd_en, mem_rd_addr, det_pixel_valid, det_pixel_data,
            res_valid, res_motion, res_intensity, res_grid, res_timeout, motion_alarm, busy,
            stat_frames, stat_motion} != '0), 0);
      rst_n = 1'b1;
      cycle();
      enable = 1'b1;

      // Warm-up, then alarm confirmation on consecutive motion frames.
      offer_frame(1'b0, 1'b1, 8'h3C, 3, -1, -1, 1'b0);
      offer_frame(1'b0, 1'b1, 8'h3C, 5, -1, -1, 1'b0);
      offer_frame(1'b0, 1'b1, 8'h3C, 2, -1, -1, 1'b1);
      // Alarm release on consecutive quiet frames; one drops frame_ready mid-burst.
      offer_frame(1'b0, 1'b0, 8'($urandom), 1, -1, 40, 1'b0);
      offer_frame(1'b0, 1'b0, 8'($urandom), 7, -1, -1, 1'b0);
      offer_frame(1'b0, 1'b0, 8'($urandom), 4, -1, -1, 1'b0);

      // Random detector outcomes.
      for (int i = 0; i < 6; i++)
         offer_frame(1'b0, 1'($urandom), 8'($urandom), $urandom_range(1, 20), -1, -1, 1'b0);

      // Watchdog: a timed-out frame must not disturb the hysteresis run.
      repeat (3) offer_frame(1'b0, 1'b0, 8'($urandom), 2, -1, -1, 1'b0);
      offer_frame(1'b0, 1'b1, 8'h55, 2, -1, -1, 1'b0);
      offer_frame(1'b1, 1'b1, 8'h00, 1, -1, -1, 1'b0);
      offer_frame(1'b0, 1'b1, 8'h66, 3, -1, -1, 1'b0);

      // Decimation: skip two frames after every processed one.
      cfg_skip = 4'd2;
      for (int i = 0; i < 9; i++) begin
         offer_frame(1'b0, 1'($urandom), 8'($urandom), $urandom_range(1, 10), -1, -1, 1'b0);
         pattern[i] = last_streamed;
      end
      check("skip_pattern", pattern, 9'b001_001_001);
      cfg_skip = 4'd0;

      // enable falls mid-burst: the frame finishes, nothing new starts.
      offer_frame(1'b0, 1'($urandom), 8'($urandom), 6, 100, -1, 1'b0);
      quiet_ok = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (mem_rd_en || det_pixel_valid || frame_ack || busy) quiet_ok = 1'b0;
         cycle();
      end
      check("enable_low_no_start", 32'(quiet_ok), 1);
      enable = 1'b1;

      // Reset in the middle of a burst.
      repeat (40) cycle();
      #2;
      check("busy_mid_stream", busy, 1);
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs_zero", 32'({frame_ack, mem_rd_en, mem_rd_addr, det_pixel_valid,
            det_pixel_data, res_valid, res_motion, res_intensity, res_grid, res_timeout, motion_alarm,
            busy, stat_frames, stat_motion} != '0), 0);
      cycle();
      cycle();
      rst_n = 1'b1;
      model_reset();
      offer_frame(1'b0, 1'b1, 8'h3C, 3, -1, -1, 1'b0);
      offer_frame(1'b0, 1'b1, 8'h3C, 3, -1, -1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
